// File: rtl/cronometro_pkg.sv
// Shared constants for the stopwatch display path: active-high 7-segment
// patterns ({g,f,e,d,c,b,a}) and the number of display digits.
package cronometro_pkg;

  localparam int NUM_DIGITS = 4;

  localparam logic [6:0] SEG_0     = 7'h3F;
  localparam logic [6:0] SEG_1     = 7'h06;
  localparam logic [6:0] SEG_2     = 7'h5B;
  localparam logic [6:0] SEG_3     = 7'h4F;
  localparam logic [6:0] SEG_4     = 7'h66;
  localparam logic [6:0] SEG_5     = 7'h6D;
  localparam logic [6:0] SEG_6     = 7'h7D;
  localparam logic [6:0] SEG_7     = 7'h07;
  localparam logic [6:0] SEG_8     = 7'h7F;
  localparam logic [6:0] SEG_9     = 7'h6F;
  localparam logic [6:0] SEG_BLANK = 7'h00;

endpackage

// File: rtl/bcd_to_7seg.sv
// BCD to active-high 7-segment pattern; non-decimal codes 10..15 decode to blank.
module bcd_to_7seg
  import cronometro_pkg::*;
(
  input  logic [3:0] bcd,
  output logic [6:0] seg
);

  // digit lookup
  always_comb begin
    seg = SEG_BLANK;
    case (bcd)
      4'd0:    seg = SEG_0;
      4'd1:    seg = SEG_1;
      4'd2:    seg = SEG_2;
      4'd3:    seg = SEG_3;
      4'd4:    seg = SEG_4;
      4'd5:    seg = SEG_5;
      4'd6:    seg = SEG_6;
      4'd7:    seg = SEG_7;
      4'd8:    seg = SEG_8;
      4'd9:    seg = SEG_9;
      default: seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/display_scan_7seg.sv
// Four-digit common-anode 7-segment scanner with per-slot blanking and frame-coherent
// digit sampling. Defining LEADING_ZERO_BLANK_EN blanks leading zeros on digits 3..1.
module display_scan_7seg
  import cronometro_pkg::*;
#(
  parameter int SCAN_DIV       = 50000,
  parameter int BLANK_CYCLES   = 500,
  parameter int SEG_ACTIVE_LOW = 1,
  parameter int AN_ACTIVE_LOW  = 1
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [3:0] digito0,
  input  logic [3:0] digito1,
  input  logic [3:0] digito2,
  input  logic [3:0] digito3,
  input  logic [3:0] ponto,
  input  logic       habilita,
  output logic [6:0] segmentos,
  output logic       dp,
  output logic [3:0] anodo
);

  localparam int               CNT_W     = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(SCAN_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_BLANK = CNT_W'(BLANK_CYCLES);
  localparam logic [3:0]       AN_OFF    = (AN_ACTIVE_LOW != 0) ? 4'hF : 4'h0;
  localparam logic [6:0]       SEG_OFF   = (SEG_ACTIVE_LOW != 0) ? 7'h7F : 7'h00;
  localparam logic             DP_OFF    = (SEG_ACTIVE_LOW != 0) ? 1'b1 : 1'b0;

  logic [CNT_W-1:0] cnt_r;
  logic [1:0]       idx_r;
  logic [3:0]       shadow_r [NUM_DIGITS];
  logic [3:0]       ponto_r;
  logic             tick_s;
  logic             frame_end_s;
  logic [3:0]       lz_blank_s;
  logic [3:0]       digit_s;
  logic [6:0]       pattern_s;
  logic [3:0]       an_log_s;
  logic [3:0]       an_s;
  logic [6:0]       seg_s;
  logic             dp_s;
  logic [3:0]       anodo_r;
  logic [6:0]       seg_r;
  logic             dp_r;

  assign tick_s      = (cnt_r == CNT_LAST);
  assign frame_end_s = tick_s && (idx_r == 2'd3);

  // prescaler, slot index and frame-boundary shadow capture
  always_ff @(posedge clock) begin
    if (reset) begin
      cnt_r       <= '0;
      idx_r       <= 2'd0;
      shadow_r[0] <= 4'd0;
      shadow_r[1] <= 4'd0;
      shadow_r[2] <= 4'd0;
      shadow_r[3] <= 4'd0;
      ponto_r     <= 4'd0;
    end else begin
      cnt_r <= tick_s ? '0 : cnt_r + CNT_W'(1);
      if (tick_s) begin
        idx_r <= idx_r + 2'd1;
      end
      if (frame_end_s) begin
        shadow_r[0] <= digito0;
        shadow_r[1] <= digito1;
        shadow_r[2] <= digito2;
        shadow_r[3] <= digito3;
        ponto_r     <= ponto;
      end
    end
  end

`ifdef LEADING_ZERO_BLANK_EN
  // a zero digit is blanked only while every digit to its left is also zero
  always_comb begin
    lz_blank_s    = 4'b0000;
    lz_blank_s[3] = (shadow_r[3] == 4'd0);
    lz_blank_s[2] = lz_blank_s[3] && (shadow_r[2] == 4'd0);
    lz_blank_s[1] = lz_blank_s[2] && (shadow_r[1] == 4'd0);
  end
`else
  assign lz_blank_s = 4'b0000;
`endif

  // code 15 is a non-decimal code, so the decoder renders it blank
  assign digit_s = lz_blank_s[idx_r] ? 4'd15 : shadow_r[idx_r];

  bcd_to_7seg u_dec (
    .bcd (digit_s),
    .seg (pattern_s)
  );

  // lit-anode selection and output polarity
  always_comb begin
    an_log_s = 4'b0000;
    if (habilita && (cnt_r >= CNT_BLANK)) begin
      an_log_s[idx_r] = 1'b1;
    end else begin
      an_log_s = 4'b0000;
    end
    if (AN_ACTIVE_LOW != 0) begin
      an_s = ~an_log_s;
    end else begin
      an_s = an_log_s;
    end
    if (SEG_ACTIVE_LOW != 0) begin
      seg_s = ~pattern_s;
      dp_s  = ~ponto_r[idx_r];
    end else begin
      seg_s = pattern_s;
      dp_s  = ponto_r[idx_r];
    end
  end

  // output registers
  always_ff @(posedge clock) begin
    if (reset) begin
      anodo_r <= AN_OFF;
      seg_r   <= SEG_OFF;
      dp_r    <= DP_OFF;
    end else begin
      anodo_r <= an_s;
      seg_r   <= seg_s;
      dp_r    <= dp_s;
    end
  end

  assign anodo     = anodo_r;
  assign segmentos = seg_r;
  assign dp        = dp_r;

endmodule

// File: tb/tb_display_scan_7seg.sv
// Self-checking bench for display_scan_7seg (SCAN_DIV=4, BLANK_CYCLES=1, active-low);
// compile with LEADING_ZERO_BLANK_EN defined to exercise the leading-zero variant.
module tb_display_scan_7seg;

  localparam int SD    = 4;
  localparam int BLK   = 1;
  localparam int FRAME = SD * 4;

  logic       clock;
  logic       reset;
  logic [3:0] digito0, digito1, digito2, digito3;
  logic [3:0] ponto;
  logic       habilita;
  logic [6:0] segmentos;
  logic       dp;
  logic [3:0] anodo;

  int errors = 0;
  int checks = 0;

  // reference state: cycles since reset, plus the digits/points currently on display
  int          m_t = 0;
  logic [15:0] m_sh = 16'h0000;
  logic [3:0]  m_pt = 4'h0;
  int          prev_cnt;
  int          prev_idx;

  logic [6:0] seg_lut [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                               7'h7F, 7'h6F, 7'h00, 7'h00, 7'h00, 7'h00, 7'h00, 7'h00};

  typedef struct packed {
    logic [15:0] digs;  // {d3,d2,d1,d0}
    logic [3:0]  pt;
    logic [27:0] seg;   // expected active-low segments {s3,s2,s1,s0}
    logic [3:0]  dpn;   // expected active-low dp {dp3..dp0}
  } vec_t;

  vec_t tbl [5];

  display_scan_7seg #(
    .SCAN_DIV       (SD),
    .BLANK_CYCLES   (BLK),
    .SEG_ACTIVE_LOW (1),
    .AN_ACTIVE_LOW  (1)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .digito0   (digito0),
    .digito1   (digito1),
    .digito2   (digito2),
    .digito3   (digito3),
    .ponto     (ponto),
    .habilita  (habilita),
    .segmentos (segmentos),
    .dp        (dp),
    .anodo     (anodo)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic check(input string name, input logic [11:0] act, input logic [11:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0d)", name, act, exp, m_t);
    end
  endtask

  // one clock: predict next outputs from the reference, advance it, compare
  task automatic step();
    logic [3:0] e_an;
    logic [6:0] e_seg;
    logic       e_dp;
    logic [3:0] blank;
    logic       seen;
    int         c;
    int         ix;
    c  = m_t % SD;
    ix = (m_t / SD) % 4;
    blank = 4'b0000;
`ifdef LEADING_ZERO_BLANK_EN
    seen = 1'b0;
    for (int k = 3; k >= 1; k--) begin
      if (m_sh[k*4 +: 4] != 4'd0) seen = 1'b1;
      blank[k] = !seen;
    end
`else
    seen = 1'b0;
`endif
    if (reset) begin
      e_an  = 4'hF;
      e_seg = 7'h7F;
      e_dp  = 1'b1;
    end else begin
      e_an  = (habilita && c >= BLK) ? (4'hF ^ (4'b0001 << ix)) : 4'hF;
      e_seg = blank[ix] ? 7'h7F : ~seg_lut[m_sh[ix*4 +: 4]];
      e_dp  = ~m_pt[ix];
    end
    prev_cnt = c;
    prev_idx = ix;
    if (reset) begin
      m_t  = 0;
      m_sh = 16'h0000;
      m_pt = 4'h0;
    end else begin
      if (m_t % FRAME == FRAME - 1) begin
        m_sh = {digito3, digito2, digito1, digito0};
        m_pt = ponto;
      end
      m_t++;
    end
    @(posedge clock);
    #1;
    check("model", {anodo, segmentos, dp}, {e_an, e_seg, e_dp});
  endtask

  task automatic run_until(input int phase);
    while (m_t % FRAME != phase) step();
  endtask

  task automatic set_digits(input logic [15:0] d);
    {digito3, digito2, digito1, digito0} = d;
  endtask

  initial begin
    vec_t v;
    logic [6:0] exp_s;

    tbl[0] = '{digs: 16'h4321, pt: 4'b0000, seg: {7'h19, 7'h30, 7'h24, 7'h79}, dpn: 4'b1111};
    tbl[1] = '{digs: 16'h8C79, pt: 4'b0100, seg: {7'h00, 7'h7F, 7'h78, 7'h10}, dpn: 4'b1011};
`ifdef LEADING_ZERO_BLANK_EN
    tbl[2] = '{digs: 16'h0050, pt: 4'b0000, seg: {7'h7F, 7'h7F, 7'h12, 7'h40}, dpn: 4'b1111};
    tbl[3] = '{digs: 16'h0000, pt: 4'b1001, seg: {7'h7F, 7'h7F, 7'h7F, 7'h40}, dpn: 4'b0110};
`else
    tbl[2] = '{digs: 16'h0050, pt: 4'b0000, seg: {7'h40, 7'h40, 7'h12, 7'h40}, dpn: 4'b1111};
    tbl[3] = '{digs: 16'h0000, pt: 4'b1001, seg: {7'h40, 7'h40, 7'h40, 7'h40}, dpn: 4'b0110};
`endif
    tbl[4] = '{digs: 16'h600F, pt: 4'b0000, seg: {7'h02, 7'h40, 7'h40, 7'h7F}, dpn: 4'b1111};

    reset    = 1'b1;
    habilita = 1'b1;
    ponto    = 4'b0000;
    set_digits(16'h4321);

    // reset for 3 cycles, then the first frame must show zeros from the cleared shadows
    repeat (3) step();
    reset = 1'b0;
    repeat (FRAME) begin
      step();
      if (prev_cnt >= BLK) begin
        check("first_frame_seg", {5'd0, segmentos}, {5'd0, 7'h40});
        check("first_frame_an", {8'd0, anodo}, {8'd0, 4'hF ^ (4'b0001 << prev_idx)});
      end else begin
        check("slot_blank", {8'd0, anodo}, 12'h00F);
      end
    end
    repeat (FRAME) step();

    // mid-frame change of digit 0 is held back until the next frame boundary
    run_until(SD);
    digito0 = 4'd9;
    run_until(0);
    step();
    step();
    check("frame_coherent_d0", {5'd0, segmentos}, {5'd0, 7'h10});

    // display disabled for 10 cycles mid-frame
    run_until(6);
    habilita = 1'b0;
    repeat (10) begin
      step();
      check("disabled_an", {8'd0, anodo}, 12'h00F);
    end
    habilita = 1'b1;
    repeat (FRAME) step();

    // reset asserted mid-slot
    run_until(10);
    reset = 1'b1;
    step();
    check("midslot_reset", {anodo, segmentos, dp}, {4'hF, 7'h7F, 1'b1});
    reset = 1'b0;

    // directed vectors: apply at a frame start, shown from the following frame
    for (int i = 0; i < 5; i++) begin
      v = tbl[i];
      run_until(0);
      set_digits(v.digs);
      ponto = v.pt;
      repeat (FRAME) step();
      repeat (FRAME) begin
        step();
        if (prev_cnt >= BLK) begin
          exp_s = v.seg[prev_idx*7 +: 7];
          check("vec_seg", {5'd0, segmentos}, {5'd0, exp_s});
          check("vec_dp", {11'd0, dp}, {11'd0, v.dpn[prev_idx]});
        end
      end
    end

    // randomized traffic against the reference
    for (int n = 0; n < 600; n++) begin
      if ($urandom_range(0, 7) == 0) begin
        digito0 = ($urandom_range(0, 2) == 0) ? 4'd0 : 4'($urandom_range(0, 15));
        digito1 = ($urandom_range(0, 2) == 0) ? 4'd0 : 4'($urandom_range(0, 15));
        digito2 = ($urandom_range(0, 2) == 0) ? 4'd0 : 4'($urandom_range(0, 15));
        digito3 = ($urandom_range(0, 2) == 0) ? 4'd0 : 4'($urandom_range(0, 15));
        ponto   = 4'($urandom_range(0, 15));
      end
      habilita = ($urandom_range(0, 9) != 0);
      reset    = ($urandom_range(0, 149) == 0);
      step();
    end
    reset    = 1'b0;
    habilita = 1'b1;
    repeat (2 * FRAME) step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
